// File: rtl/stch_to_dec_pkg.sv
// Shared stochastic datapath definitions: default precision, conversion FSM states,
// and output saturation used by the stochastic-to-decimal read-out.
package stch_to_dec_pkg;

    localparam int unsigned ND_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } stch_state_e;

    // Clamp a count to the largest nd-bit value; only a full window of ones needs it.
    function automatic logic [31:0] sat(input logic [31:0] x, input int unsigned nd);
        logic [31:0] lim;
        lim = (32'd1 << nd) - 32'd1;
        return (x > lim) ? lim : x;
    endfunction

endpackage

// File: rtl/stch_ones_counter.sv
// Window accumulator: counts qualified ones and flags the last sample of a 2^ND window.
module stch_ones_counter
    import stch_to_dec_pkg::*;
#(
    parameter int unsigned ND = ND_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic        s_bit,
    output logic [ND:0] ones,
    output logic        done_c
);

    localparam logic [ND-1:0] ONE_S = 1;

    logic [ND-1:0] samples;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ones    <= '0;
            samples <= '0;
        end else if (enable) begin
            ones    <= ones + {{ND{1'b0}}, s_bit};
            samples <= samples + ONE_S;
        end
    end

    // The final qualified sample of the window is the one arriving with samples all-ones.
    assign done_c = enable & (&samples);

endmodule

// File: rtl/stch_to_dec.sv
// Stochastic-to-decimal converter: ones count over 2^ND qualified bits, presented as an
// ND-bit fraction with a start/valid/ack handshake.
module stch_to_dec
    import stch_to_dec_pkg::*;
#(
    parameter int unsigned ND = ND_DEF
) (
    input  logic          CLK,
    input  logic          INIT,
    input  logic          S,
    input  logic          EN,
    input  logic          START,
    input  logic          ACK,
    output logic [ND-1:0] D,
    output logic          VALID,
    output logic          BUSY
);

    stch_state_e   state;
    logic [ND:0]   ones;
    logic [ND:0]   ones_fin_c;
    logic          done_c;
    logic          clear_c;
    logic          cnt_en_c;

    // A new window opens from IDLE, or straight out of HOLD when ACK and START coincide.
    assign clear_c    = START & ((state == IDLE) | ((state == HOLD) & ACK));
    assign cnt_en_c   = (state == ACCUM) & EN;
    assign ones_fin_c = ones + {{ND{1'b0}}, S};

    stch_ones_counter #(.ND(ND)) u_cnt (
        .clk    (CLK),
        .rst    (INIT),
        .clear  (clear_c),
        .enable (cnt_en_c),
        .s_bit  (S),
        .ones   (ones),
        .done_c (done_c)
    );

    always_ff @(posedge CLK) begin
        if (INIT) begin
            state <= IDLE;
            D     <= '0;
            VALID <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        state <= ACCUM;
                        BUSY  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (done_c) begin
                        D     <= ND'(sat(32'(ones_fin_c), ND));
                        VALID <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (ACK) begin
                        VALID <= 1'b0;
                        if (START) begin
                            state <= ACCUM;
                            BUSY  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    VALID <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stch_to_dec.sv
// Bench for stch_to_dec: table of pattern windows, handshake/INIT sequences, and random
// windows checked against a window-sum model.
module tb_stch_to_dec;

    localparam int unsigned ND  = 8;
    localparam int          WIN = 256;

    logic          CLK;
    logic          INIT;
    logic          S;
    logic          EN;
    logic          START;
    logic          ACK;
    logic [ND-1:0] D;
    logic          VALID;
    logic          BUSY;

    int total = 0;
    int bad   = 0;

    stch_to_dec #(.ND(ND)) dut (
        .CLK   (CLK),
        .INIT  (INIT),
        .S     (S),
        .EN    (EN),
        .START (START),
        .ACK   (ACK),
        .D     (D),
        .VALID (VALID),
        .BUSY  (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string name;
        int    s_mode;
        int    en_mode;
        int    exp_d;
        int    tol;
        int    exp_lat;
    } vec_t;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp, input int tol = 0);
        total++;
        if (act < exp - tol || act > exp + tol) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", name, act, exp, tol, $time);
        end
    endtask

    // Runs one window from IDLE (or from HOLD via ACK+START) with a patterned S/EN stream.
    task automatic run_window(input int s_mode, input int en_mode, input bit ack_start,
                              output int d_out, output int lat);
        int         k;
        logic [7:0] lf;
        logic       sb;
        logic       eb;
        k  = 0;
        lf = 8'd1;
        if (ack_start) begin
            ACK = 1'b1; START = 1'b1;
            tick();
            ACK = 1'b0; START = 1'b0;
            chk("valid_drop_on_ack_start", int'(VALID), 0);
        end else begin
            START = 1'b1;
            tick();
            START = 1'b0;
        end
        chk("busy_after_start", int'(BUSY), 1);
        lat = -1;
        for (int c = 0; c < 2000; c++) begin
            eb = (en_mode == 0) ? 1'b1 : (c % 2 == 0);
            case (s_mode)
                0:       sb = 1'b1;
                1:       sb = 1'b0;
                2:       sb = (k % 2 == 0);
                3:       sb = (k == 0);
                4:       sb = eb;
                5:       sb = ~eb;
                default: sb = (8'd64 >= lf);
            endcase
            S = sb; EN = eb;
            tick();
            if (eb) begin
                k++;
                lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
            end
            if (VALID) begin
                lat = c + 1;
                break;
            end
        end
        S = 1'b0; EN = 1'b0;
        if (lat < 0) chk("window_timeout", 0, 1);
        chk("busy_low_at_valid", int'(BUSY), 0);
        d_out = int'(D);
    endtask

    task automatic do_ack(input int d_hold);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("valid_low_after_ack", int'(VALID), 0);
        chk("d_kept_after_ack", int'(D), d_hold);
    endtask

    // Random windows: expected D is the clamped sum of the first 256 qualified bits, and
    // VALID is expected one edge after the 256th qualified sample.
    task automatic run_random(input int n);
        bit chain;
        int p, duty, cnt, q, lat, exp_lat, h, d_hold;
        chain = 1'b0;
        for (int w = 0; w < n; w++) begin
            p    = int'($urandom_range(0, 256));
            duty = int'($urandom_range(1, 4));
            cnt = 0; q = 0; lat = -1; exp_lat = -1;
            if (!chain) begin
                START = 1'b1;
                tick();
                START = 1'b0;
            end
            for (int c = 0; c < 3000; c++) begin
                EN    = ($urandom_range(1, 4) <= duty);
                S     = ($urandom_range(0, 255) < p);
                START = ($urandom_range(0, 7) == 0);
                if (EN && q < WIN) begin
                    q++;
                    cnt += int'(S);
                    if (q == WIN) exp_lat = c + 1;
                end
                tick();
                if (VALID) begin
                    lat = c + 1;
                    break;
                end
            end
            START = 1'b0; EN = 1'b0; S = 1'b0;
            chk("rand_latency", lat, exp_lat);
            chk("rand_d", int'(D), (cnt > WIN - 1) ? WIN - 1 : cnt);
            d_hold = int'(D);
            h = int'($urandom_range(0, 4));
            for (int i = 0; i < h; i++) begin
                START = $urandom_range(0, 1) == 1;
                tick();
                chk("rand_hold_valid", int'(VALID), 1);
                chk("rand_hold_d", int'(D), d_hold);
            end
            chain = (w < n - 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
            ACK = 1'b1; START = chain;
            tick();
            ACK = 1'b0; START = 1'b0;
            chk("rand_valid_after_ack", int'(VALID), 0);
            chk("rand_busy_after_ack", int'(BUSY), int'(chain));
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   d, lat;

        vecs[0] = '{"all_ones",      0, 0, 255, 0, 256};
        vecs[1] = '{"all_zeros",     1, 0,   0, 0, 256};
        vecs[2] = '{"alternating",   2, 0, 128, 0, 256};
        vecs[3] = '{"first_only",    3, 0,   1, 0, 256};
        vecs[4] = '{"en_tog_s_en",   4, 1, 255, 0, 511};
        vecs[5] = '{"en_tog_s_inv",  5, 1,   0, 0, 511};
        vecs[6] = '{"lfsr_d64",      6, 0,  65, 1, 256};

        INIT = 1'b1; S = 1'b0; EN = 1'b0; START = 1'b0; ACK = 1'b0;
        tick();
        INIT = 1'b0;
        repeat (5) tick();
        chk("reset_d", int'(D), 0);
        chk("reset_valid", int'(VALID), 0);
        chk("reset_busy", int'(BUSY), 0);

        // ACK while idle must not disturb anything.
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("idle_ack_valid", int'(VALID), 0);
        chk("idle_ack_busy", int'(BUSY), 0);

        foreach (vecs[i]) begin
            run_window(vecs[i].s_mode, vecs[i].en_mode, 1'b0, d, lat);
            chk({vecs[i].name, "_d"}, d, vecs[i].exp_d, vecs[i].tol);
            chk({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
            chk({vecs[i].name, "_valid"}, int'(VALID), 1);
            do_ack(d);
            tick();
        end

        // Long HOLD with START pulses and no ACK, then ACK+START back-to-back.
        run_window(0, 0, 1'b0, d, lat);
        chk("hold_first_d", d, 255);
        for (int i = 0; i < 20; i++) begin
            START = (i % 5 == 2);
            tick();
            chk("hold_valid", int'(VALID), 1);
            chk("hold_d", int'(D), 255);
            chk("hold_busy", int'(BUSY), 0);
        end
        START = 1'b0;
        run_window(2, 0, 1'b1, d, lat);
        chk("b2b_d", d, 128);
        chk("b2b_lat", lat, 256);
        do_ack(128);

        // INIT mid-window wins over START/ACK and leaves no residue in the next window.
        START = 1'b1;
        tick();
        START = 1'b0;
        S = 1'b1; EN = 1'b1;
        repeat (100) tick();
        INIT = 1'b1; START = 1'b1; ACK = 1'b1;
        tick();
        INIT = 1'b0; START = 1'b0; ACK = 1'b0; S = 1'b0; EN = 1'b0;
        chk("init_d", int'(D), 0);
        chk("init_valid", int'(VALID), 0);
        chk("init_busy", int'(BUSY), 0);
        tick();
        chk("init_start_ignored", int'(BUSY), 0);
        run_window(3, 0, 1'b0, d, lat);
        chk("post_init_d", d, 1);
        chk("post_init_lat", lat, 256);
        do_ack(1);

        run_random(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
